// File: rtl/cfg_lut_k.sv
// cfg_lut_k: runtime-reconfigurable K-input LUT with a bit-serial, cascadable config chain.
// Latency: Z is combinational from A (0 cycles), or 1 cycle when CFG_LUT_OUTREG_EN is defined.
// Backpressure: none; CFG_VALID qualifies each config beat, and beats are ignored outside LOAD.
//
// Optional feature macro: CFG_LUT_OUTREG_EN (registered Z with clock enable CE).
//
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   A             LUT select (A[0] is the index LSB)
//   CE            output-register enable (registered build only)
//   CFG_START     one-cycle request to begin or restart a table load
//   CFG_DIN       serial table bit, MSB first, qualified by CFG_VALID
//   CFG_DOUT      shadow MSB, feeds CFG_DIN of the next instance in a chain
//   CFG_BUSY      high while loading or committing
//   CFG_DONE      one-cycle pulse in the commit cycle
//   Z             LUT output
module cfg_lut_k #(
    parameter int                 K    = 4,
    parameter logic [(1<<K)-1:0]  INIT = '0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [K-1:0] A,
    input  logic         CE,
    input  logic         CFG_START,
    input  logic         CFG_DIN,
    input  logic         CFG_VALID,
    output logic         CFG_DOUT,
    output logic         CFG_BUSY,
    output logic         CFG_DONE,
    output logic         Z
);

    localparam int N = 1 << K;
    localparam logic [K-1:0] CNT_LAST = '1;
    localparam logic [K-1:0] CNT_ONE  = K'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   tbl;    // active table, drives Z
    logic [N-1:0]   shd;    // shadow table, filled serially
    logic [K-1:0]   cnt;    // beats accepted in the current load

    // CFG_BUSY and CFG_DONE are registered alongside the state so they are
    // glitch-free; each is set from the state being entered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            tbl      <= INIT;
            shd      <= '0;
            cnt      <= '0;
            CFG_BUSY <= 1'b0;
            CFG_DONE <= 1'b0;
        end else begin
            CFG_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    // Shadow is deliberately kept: in a cascade the upstream
                    // shadow from the previous load flows into the next one.
                    if (CFG_START) begin
                        state    <= LOAD;
                        cnt      <= '0;
                        CFG_BUSY <= 1'b1;
                    end
                end
                LOAD: begin
                    // A restart wins over a beat arriving in the same cycle.
                    if (CFG_START) begin
                        cnt <= '0;
                    end else if (CFG_VALID) begin
                        shd <= {shd[N-2:0], CFG_DIN};
                        cnt <= cnt + CNT_ONE;
                        if (cnt == CNT_LAST) begin
                            state    <= COMMIT;
                            CFG_DONE <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    tbl      <= shd;
                    state    <= IDLE;
                    CFG_BUSY <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    CFG_BUSY <= 1'b0;
                end
            endcase
        end
    end

    assign CFG_DOUT = shd[N-1];

`ifdef CFG_LUT_OUTREG_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Z <= 1'b0;
        end else if (CE) begin
            Z <= tbl[A];
        end
    end
`else
    // The active table only changes at the commit edge, so Z never sees a
    // partially shifted table.
    assign Z = tbl[A];

    logic unused_ce;
    assign unused_ce = CE;
`endif

endmodule

// File: tb/tb_cfg_lut_k.sv
module tb_cfg_lut_k;

    localparam int K = 4;
    localparam int N = 16;
    localparam logic [N-1:0] INIT_V = 16'h8000;

    logic         clk = 1'b0;
    logic         rst;
    logic         ce;
    logic         cfg_start;
    logic         cfg_din;
    logic         cfg_valid;
    logic [K-1:0] a;
    logic         dout0, busy0, done0, z0;
    logic         dout1, busy1, done1, z1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the chain is a stream of accepted bits; instance n's
    // shadow holds the 16 bits that sit 16*n positions back from the newest.
    bit           hist[$];
    logic [N-1:0] tbl_m0, tbl_m1;

    always #5 clk = ~clk;

    cfg_lut_k #(.K(K), .INIT(INIT_V)) dut0 (
        .CLK(clk), .RST(rst), .A(a), .CE(ce),
        .CFG_START(cfg_start), .CFG_DIN(cfg_din), .CFG_VALID(cfg_valid),
        .CFG_DOUT(dout0), .CFG_BUSY(busy0), .CFG_DONE(done0), .Z(z0)
    );

    cfg_lut_k #(.K(K), .INIT(INIT_V)) dut1 (
        .CLK(clk), .RST(rst), .A(a), .CE(ce),
        .CFG_START(cfg_start), .CFG_DIN(dout0), .CFG_VALID(cfg_valid),
        .CFG_DOUT(dout1), .CFG_BUSY(busy1), .CFG_DONE(done1), .Z(z1)
    );

    function automatic logic [N-1:0] shadow_of(input int skip);
        logic [N-1:0] v;
        int idx;
        v = '0;
        for (int j = 0; j < N; j++) begin
            idx = hist.size() - 1 - skip - j;
            if (idx >= 0) v[j] = hist[idx];
        end
        return v;
    endfunction

    // Drives one full load of val (optionally with random VALID gaps and a
    // restart after restart_at junk beats), checking BUSY/DONE and that Z
    // keeps the old table, then sweeps both tables afterwards.
    task automatic run_load(input logic [N-1:0] val, input int maxgap,
                            input int restart_at, output int done_cyc);
        int cyc, sent, dones, gap, last_beat;
        bit restarted;
        logic [N-1:0] old0, old1;
        old0 = tbl_m0; old1 = tbl_m1;
        cyc = 0; sent = 0; dones = 0; gap = 0; last_beat = 0;
        restarted = 0; done_cyc = -1;
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_valid = 1'($urandom_range(0, 1));   // ignored in IDLE
        cfg_din   = 1'($urandom_range(0, 1));
        while (dones == 0 && cyc < 200) begin
            a = K'($urandom_range(0, N-1));
            #1;
`ifndef CFG_LUT_OUTREG_EN
            n_cmp++;
            if (z0 !== old0[a] || z1 !== old1[a]) begin
                n_err++;
                $display("FAIL z_during_load cyc=%0d a=%0d got=%b/%b want=%b/%b",
                         cyc, a, z0, z1, old0[a], old1[a]);
            end
`endif
            @(negedge clk);
            cyc++;
            cfg_start = 1'b0;
            cfg_valid = 1'b0;
            cfg_din   = 1'($urandom_range(0, 1));
            n_cmp++;
            if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
                n_err++;
                $display("FAIL busy_in_load cyc=%0d got=%b/%b want=1", cyc, busy0, busy1);
            end
            n_cmp++;
            if (done1 !== done0) begin
                n_err++;
                $display("FAIL cascade_done_align cyc=%0d got=%b want=%b", cyc, done1, done0);
            end
            if (done0 === 1'b1) begin
                dones    = 1;
                done_cyc = cyc;
            end else if (restart_at >= 0 && !restarted && sent == restart_at) begin
                cfg_start = 1'b1;
                cfg_valid = 1'b1;                 // discarded beat
                restarted = 1;
                sent      = 0;
            end else if (sent < N) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    cfg_valid = 1'b1;
                    if (!(restart_at >= 0 && !restarted)) cfg_din = val[N-1-sent];
                    hist.push_back(cfg_din);
                    sent++;
                    last_beat = cyc;
                    gap = $urandom_range(0, maxgap);
                end
            end
        end
        n_cmp++;
        if (dones != 1 || done_cyc != last_beat + 1) begin
            n_err++;
            $display("FAIL done_timing got=%0d want=%0d", done_cyc, last_beat + 1);
        end
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        n_cmp++;
        if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            n_err++;
            $display("FAIL post_commit got done=%b busy=%b want 0/0", done0, busy0);
        end
        tbl_m0 = shadow_of(0);
        tbl_m1 = shadow_of(N);
        n_cmp++;
        if (dout0 !== tbl_m0[N-1]) begin
            n_err++;
            $display("FAIL cfg_dout got=%b want=%b", dout0, tbl_m0[N-1]);
        end
`ifndef CFG_LUT_OUTREG_EN
        for (int i = 0; i < N; i++) begin
            a = K'(i);
            #1;
            n_cmp++;
            if (z0 !== tbl_m0[i] || z1 !== tbl_m1[i]) begin
                n_err++;
                $display("FAIL table_sweep a=%0d got=%b/%b want=%b/%b",
                         i, z0, z1, tbl_m0[i], tbl_m1[i]);
            end
        end
`endif
    endtask

    task automatic test_reset;
        rst = 1'b1; ce = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_din = 1'b0; a = '0;
        hist.delete();
        tbl_m0 = INIT_V; tbl_m1 = INIT_V;
        for (int i = 0; i < N; i++) begin
            a = K'(i);
            #1;
            n_cmp++;
`ifdef CFG_LUT_OUTREG_EN
            if (z0 !== 1'b0) begin
                n_err++;
                $display("FAIL reset_z a=%0d got=%b want=0", i, z0);
            end
`else
            if (z0 !== (i == 15)) begin
                n_err++;
                $display("FAIL reset_z a=%0d got=%b want=%b", i, z0, (i == 15));
            end
`endif
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || dout0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags got busy=%b done=%b dout=%b want 0/0/0", busy0, done0, dout0);
        end
    endtask

    task automatic test_load_contig;
        int dc;
        run_load(16'h6996, 0, -1, dc);
        n_cmp++;
        if (dc != 17) begin
            n_err++;
            $display("FAIL done_cycle got=%0d want=17", dc);
        end
`ifndef CFG_LUT_OUTREG_EN
        for (int i = 0; i < N; i++) begin
            logic [K-1:0] ai;
            ai = K'(i);
            a = ai;
            #1;
            n_cmp++;
            if (z0 !== ^ai) begin
                n_err++;
                $display("FAIL parity a=%0d got=%b want=%b", i, z0, ^ai);
            end
        end
`endif
    endtask

    task automatic test_load_gaps;
        int dc;
        run_load(16'($urandom), 3, -1, dc);
        run_load(16'h6996, 3, -1, dc);
        n_cmp++;
        if (tbl_m0 !== 16'h6996) begin
            n_err++;
            $display("FAIL gap_load model got=%h want=6996", tbl_m0);
        end
    endtask

    task automatic test_restart;
        int dc;
        run_load(16'hFFFE, 1, 7, dc);
`ifndef CFG_LUT_OUTREG_EN
        for (int i = 0; i < N; i++) begin
            a = K'(i);
            #1;
            n_cmp++;
            if (z0 !== (i != 0)) begin
                n_err++;
                $display("FAIL or4 a=%0d got=%b want=%b", i, z0, (i != 0));
            end
        end
`endif
    endtask

    task automatic test_reset_midload;
        int dc;
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cfg_valid = 1'b1;
            cfg_din   = 1'b1;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || dout0 !== 1'b0 || dout1 !== 1'b0) begin
            n_err++;
            $display("FAIL midload_reset got busy=%b done=%b dout=%b/%b want 0", busy0, done0, dout0, dout1);
        end
        hist.delete();
        tbl_m0 = INIT_V; tbl_m1 = INIT_V;
`ifndef CFG_LUT_OUTREG_EN
        for (int i = 0; i < N; i++) begin
            a = K'(i);
            #1;
            n_cmp++;
            if (z0 !== (i == 15)) begin
                n_err++;
                $display("FAIL midload_init a=%0d got=%b want=%b", i, z0, (i == 15));
            end
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        run_load(16'h0001, 0, -1, dc);
`ifndef CFG_LUT_OUTREG_EN
        for (int i = 0; i < N; i++) begin
            a = K'(i);
            #1;
            n_cmp++;
            if (z0 !== (i == 0)) begin
                n_err++;
                $display("FAIL reload_0001 a=%0d got=%b want=%b", i, z0, (i == 0));
            end
        end
`endif
    endtask

    task automatic test_cascade;
        int dc;
        run_load(16'hAAAA, 0, -1, dc);
        run_load(16'h5555, 0, -1, dc);
`ifndef CFG_LUT_OUTREG_EN
        for (int i = 0; i < N; i++) begin
            a = K'(i);
            #1;
            n_cmp++;
            if (z1 !== i[0] || z0 !== !i[0]) begin
                n_err++;
                $display("FAIL cascade a=%0d got up=%b down=%b want up=%b down=%b",
                         i, z0, z1, !i[0], i[0]);
            end
        end
`endif
    endtask

    task automatic test_random;
        int dc;
        for (int r = 0; r < 4; r++) begin
            run_load(16'($urandom), $urandom_range(0, 3),
                     (r == 2) ? $urandom_range(1, 14) : -1, dc);
        end
    endtask

`ifdef CFG_LUT_OUTREG_EN
    task automatic test_outreg;
        logic exp_z;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (z0 !== 1'b0) begin
            n_err++;
            $display("FAIL outreg_reset got=%b want=0", z0);
        end
        hist.delete();
        tbl_m0 = INIT_V; tbl_m1 = INIT_V;
        @(negedge clk);
        rst = 1'b0;
        exp_z = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a  = K'($urandom_range(0, N-1));
            ce = 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if (z0 !== exp_z) begin
                n_err++;
                $display("FAIL outreg_lag i=%0d got=%b want=%b", i, z0, exp_z);
            end
            if (ce) exp_z = tbl_m0[a];
            @(posedge clk);
            #1;
            n_cmp++;
            if (z0 !== exp_z) begin
                n_err++;
                $display("FAIL outreg_capture i=%0d ce=%b got=%b want=%b", i, ce, z0, exp_z);
            end
        end
        ce = 1'b0;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_contig();
        test_load_gaps();
        test_restart();
        test_reset_midload();
        test_cascade();
        test_random();
`ifdef CFG_LUT_OUTREG_EN
        test_outreg();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cfg_lut_k.md
# cfg_lut_k

Runtime-reconfigurable K-input look-up table with a serial configuration port. It is the parametrised successor to the fixed-INIT 4-input LUT primitive. The truth table resets to a parameter value and can be reloaded in-system through a bit-serial shift chain, which can be cascaded across instances. The new table is swapped in atomically, so Z never shows a partially loaded table. It sits in the XP2 primitive library as a behavioural model for reconfigurable logic slices.

## Interface
Parameters:
- K, 4, number of LUT select inputs; legal range 2..6.
- INIT, all zeros (2^K bits), truth table loaded at reset. Bit i is the output for A == i.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- A  input  K  LUT select inputs; A[0] is the LSB of the table index.
- CE  input  1  output-register clock enable. Used only when CFG_LUT_OUTREG_EN is defined; ignored otherwise.
- CFG_START  input  1  1-cycle request to begin a table load.
- CFG_DIN  input  1  serial configuration bit, sent MSB (table bit 2^K-1) first.
- CFG_VALID  input  1  qualifies CFG_DIN.
- CFG_DOUT  output  1  shadow register MSB; drives CFG_DIN of the next instance in a cascade.
- CFG_BUSY  output  1  high in the LOAD and COMMIT states.
- CFG_DONE  output  1  1-cycle pulse when the new table becomes active.
- Z  output  1  LUT output.

## Operation
- Storage:
  - Active table TBL[2^K-1:0].
  - Shadow table SHD[2^K-1:0].
  - Bit counter CNT, K bits.
- FSM states IDLE, LOAD, COMMIT. Reset state is IDLE.
- Z = TBL[A] in every state. The old table stays active until commit.
- IDLE:
  - CFG_VALID is ignored.
  - CFG_START moves to LOAD and clears CNT to 0. SHD keeps its contents.
- LOAD, on each cycle with CFG_VALID=1:
  - SHD <= {SHD[2^K-2:0], CFG_DIN}.
  - CNT <= CNT+1.
  - If CNT == 2^K-1 on that beat, go to COMMIT. CNT wraps to 0.
- LOAD, on cycles with CFG_VALID=0: hold SHD, CNT and state.
- CFG_START in LOAD restarts the load: CNT <= 0 and stay in LOAD. A CFG_VALID beat in that same cycle is discarded. START has priority.
- COMMIT (exactly 1 cycle):
  - TBL <= SHD and CFG_DONE=1.
  - Next state is IDLE.
  - CFG_START and CFG_VALID are ignored in COMMIT.
- CFG_DOUT = SHD[2^K-1] combinationally.
  - In a cascade, bits shifted into instance n emerge at instance n+1 after 2^K beats.
  - Every instance in the chain must receive START and VALID together.
- Reset, asynchronous, any time including mid-load:
  - TBL=INIT, SHD=0, CNT=0, state IDLE.
  - CFG_BUSY=0, CFG_DONE=0, CFG_DOUT=0.
  - Z: INIT[A] when unregistered; 0 when registered.
  - A partial load is discarded.

## Timing
- Z is combinational from A and TBL. Latency is 0 (1 cycle with CFG_LUT_OUTREG_EN).
- A full load takes 2^K VALID beats, then 1 COMMIT cycle.
  - Minimum from CFG_START to CFG_DONE: 2^K+1 cycles.
  - The new table is seen at Z in the cycle after the COMMIT edge.
- CFG_BUSY rises the cycle after CFG_START and falls the cycle after CFG_DONE.
- A START accepted in IDLE in the cycle right after COMMIT is legal.

## Configuration
- CFG_LUT_OUTREG_EN defined:
  - Z comes from a flop, Z <= TBL[A] on edges with CE=1; Z holds when CE=0.
  - Z resets to 0.
  - A new table reaches Z no earlier than 1 cycle after the TBL update.
- CFG_LUT_OUTREG_EN undefined:
  - Z = TBL[A] combinationally; no flop; CE unused.
  - Z reads INIT[A] during reset.

## Test plan
- Reset with K=4, INIT=16'h8000, sweep A 0..15: Z=1 only at A=4'hF. CFG_BUSY=0, CFG_DONE=0.
- START, then 16 contiguous beats of 16'h6996 MSB-first:
  - CFG_DONE pulses at cycle 17 after START.
  - Z = odd parity of A from then on.
  - Z still follows 16'h8000 during every load cycle.
- Same load with VALID gaps of 0-3 random cycles: identical result. BUSY stays high throughout; DONE occurs exactly once.
- START, 7 beats, START again, 16 beats of 16'hFFFE: TBL=16'hFFFE (OR4). The first partial load has no effect.
- RST asserted after 9 beats of a load:
  - TBL returns to 16'h8000, state IDLE, CFG_DOUT=0.
  - A following full load of 16'h0001 succeeds.
- Two instances cascaded, 32 beats of {16'hAAAA, 16'h5555}: the downstream instance gets 16'hAAAA, the upstream gets 16'h5555. Both raise DONE in the same cycle.
- With CFG_LUT_OUTREG_EN defined: Z lags A by 1 cycle, holds while CE=0, and is 0 after reset.
